// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC owner and instruction register for a 16-bit big-endian instruction memory
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    MEM_BYTES  = 128,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] PCAddress,
  input  logic [15:0]           Instruction,
  input  logic                  Stall,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectTarget,
  output logic [15:0]           IR,
  output logic [ADDR_WIDTH-1:0] IRPC,
  output logic [ADDR_WIDTH-1:0] PCPlus2,
  output logic                  IRValid,
  output logic                  FetchFault
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(MEM_BYTES - 2);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   pc, pc_next;
  logic [15:0]             ir, ir_next;
  logic [ADDR_WIDTH-1:0]   irpc, irpc_next;
  logic                    irvalid, irvalid_next;
  logic                    bad_pc;

  // Fault is judged only when a capture would otherwise happen.
  assign bad_pc = pc[0] || (pc > LAST_PC);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (!Redirect && !Stall && bad_pc) state_next = S_FAULT;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    pc_next      = pc;
    ir_next      = ir;
    irpc_next    = irpc;
    irvalid_next = irvalid;
    case (state)
      S_IDLE: begin
        if (Redirect) pc_next = RedirectTarget;
      end
      S_FETCH: begin
        // Redirect wins over Stall so a taken branch is never lost.
        if (Redirect) begin
          pc_next      = RedirectTarget;
          irvalid_next = 1'b0;
        end else if (!Stall) begin
          if (bad_pc) begin
            irvalid_next = 1'b0;
          end else begin
            ir_next      = Instruction;
            irpc_next    = pc;
            irvalid_next = 1'b1;
            pc_next      = pc + PC_STEP;
          end
        end
      end
      default: begin
        irvalid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc      <= RESET_PC;
      ir      <= '0;
      irpc    <= '0;
      irvalid <= 1'b0;
    end else begin
      pc      <= pc_next;
      ir      <= ir_next;
      irpc    <= irpc_next;
      irvalid <= irvalid_next;
    end
  end

  assign PCAddress  = pc;
  assign IR         = ir;
  assign IRPC       = irpc;
  assign PCPlus2    = irpc + PC_STEP;
  assign IRValid    = irvalid;
  assign FetchFault = (state == S_FAULT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - self-checking bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] PCAddress;
  logic [15:0] Instruction;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectTarget;
  logic [15:0] IR;
  logic [15:0] IRPC;
  logic [15:0] PCPlus2;
  logic        IRValid;
  logic        FetchFault;

  logic [7:0]  mem [0:127];

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic [15:0] m_irpc;
  logic        m_valid;
  int          m_state;

  instruction_fetch_unit #(
    .ADDR_WIDTH(16),
    .MEM_BYTES (128),
    .RESET_PC  (16'h0000)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .PCAddress     (PCAddress),
    .Instruction   (Instruction),
    .Stall         (Stall),
    .Redirect      (Redirect),
    .RedirectTarget(RedirectTarget),
    .IR            (IR),
    .IRPC          (IRPC),
    .PCPlus2       (PCPlus2),
    .IRValid       (IRValid),
    .FetchFault    (FetchFault)
  );

  always #5 Clock = ~Clock;

  always_comb begin
    Instruction = 16'hDEAD;
    if (PCAddress < 16'd127)
      Instruction = {mem[PCAddress[6:0]], mem[PCAddress[6:0] + 7'd1]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc    = 16'h0000;
    m_ir    = 16'h0000;
    m_irpc  = 16'h0000;
    m_valid = 1'b0;
    m_state = 0;
  endfunction

  // 0 = waiting one cycle after reset, 1 = fetching, 2 = faulted for good
  function automatic void model_step(input logic st, input logic rd, input logic [15:0] tg);
    if (m_state == 0) begin
      if (rd) m_pc = tg;
      m_state = 1;
    end else if (m_state == 1) begin
      if (rd) begin
        m_pc    = tg;
        m_valid = 1'b0;
      end else if (!st) begin
        if (m_pc % 2 != 0 || m_pc > 16'd126) begin
          m_state = 2;
          m_valid = 1'b0;
        end else begin
          m_ir    = {mem[m_pc[6:0]], mem[m_pc[6:0] + 7'd1]};
          m_irpc  = m_pc;
          m_valid = 1'b1;
          m_pc    = m_pc + 16'd2;
        end
      end
    end
  endfunction

  always @(negedge Clock) begin
    if (chk_en) begin
      check("pcaddress", PCAddress, m_pc);
      check("irvalid", IRValid, m_valid);
      check("fetchfault", FetchFault, m_state == 2);
      check("ir", IR, m_ir);
      check("irpc", IRPC, m_irpc);
      check("pcplus2", PCPlus2, m_irpc + 16'd2);
    end
  end

  task automatic cyc(input logic st, input logic rd, input logic [15:0] tg);
    Stall          = st;
    Redirect       = rd;
    RedirectTarget = tg;
    @(posedge Clock);
    model_step(st, rd, tg);
    #2;
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    model_reset();
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    logic [15:0] tg;
    int          r;
    int          n;
    logic [7:0]  init_bytes [0:5];

    init_bytes[0] = 8'h12; init_bytes[1] = 8'h34; init_bytes[2] = 8'h56;
    init_bytes[3] = 8'h78; init_bytes[4] = 8'h9A; init_bytes[5] = 8'hBC;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) mem[i] = init_bytes[i];

    Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; RedirectTarget = 16'h0000;
    model_reset();
    repeat (2) @(posedge Clock);
    #2;
    check("rst_pcaddress", PCAddress, 16'h0000);
    check("rst_irvalid", IRValid, 1'b0);
    check("rst_fault", FetchFault, 1'b0);
    check("rst_pcplus2", PCPlus2, 16'h0002);
    Reset  = 1'b1;
    chk_en = 1'b1;

    cyc(0, 0, 16'h0);
    check("idle_irvalid", IRValid, 1'b0);
    cyc(0, 0, 16'h0);
    check("ir0", IR, 16'h1234);
    check("irpc0", IRPC, 16'h0000);
    cyc(0, 0, 16'h0);
    check("ir1", IR, 16'h5678);
    check("irpc1", IRPC, 16'h0002);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 16'h0);
      check("stall_ir", IR, 16'h5678);
      check("stall_irpc", IRPC, 16'h0002);
      check("stall_pcaddr", PCAddress, 16'h0004);
    end
    cyc(0, 0, 16'h0);
    check("ir2", IR, 16'h9ABC);
    check("pcplus2_2", PCPlus2, 16'h0006);

    cyc(1, 1, 16'h0002);
    check("redir_bubble", IRValid, 1'b0);
    check("redir_pcaddr", PCAddress, 16'h0002);
    cyc(0, 0, 16'h0);
    check("redir_ir", IR, 16'h5678);
    check("redir_irpc", IRPC, 16'h0002);

    cyc(0, 1, 16'h0003);
    check("mis_bubble", IRValid, 1'b0);
    check("mis_pcaddr", PCAddress, 16'h0003);
    cyc(0, 0, 16'h0);
    check("mis_fault", FetchFault, 1'b1);
    check("mis_irvalid", IRValid, 1'b0);
    cyc(1, 1, 16'h0010);
    cyc(0, 1, 16'h0020);
    check("frozen_pcaddr", PCAddress, 16'h0003);
    check("frozen_fault", FetchFault, 1'b1);
    check("frozen_ir", IR, 16'h5678);

    #1;
    Reset = 1'b0;
    #1;
    check("async_pcaddr", PCAddress, 16'h0000);
    check("async_fault", FetchFault, 1'b0);
    check("async_ir", IR, 16'h0000);
    check("async_irvalid", IRValid, 1'b0);
    model_reset();
    #1;
    Reset = 1'b1;
    cyc(0, 0, 16'h0);
    check("rel_idle", IRValid, 1'b0);
    cyc(0, 0, 16'h0);
    check("rel_ir", IR, 16'h1234);

    n = 0;
    while (!(IRValid === 1'b1 && IRPC === 16'h007E) && n < 100) begin
      cyc(0, 0, 16'h0);
      n++;
    end
    check("reach_7e_in_budget", n < 100, 1'b1);
    check("ir_7e", IR, {mem[126], mem[127]});
    cyc(0, 0, 16'h0);
    check("end_fault", FetchFault, 1'b1);
    check("end_pcaddr", PCAddress, 16'h0080);

    pulse_reset();
    for (int i = 0; i < 2000; i++) begin
      if (m_state == 2) pulse_reset();
      r  = $urandom_range(0, 19);
      tg = 16'($urandom_range(0, 63) * 2);
      if (r == 0) tg = tg | 16'h0001;
      else if (r == 1) tg = 16'h0080 + 16'($urandom_range(0, 200));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tg);
    end

    @(posedge Clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
